stack_sequencer: RTL and testbench

//  Multi-cycle stack engine between decode/execute and the register file's SP (R3) update port.

---
 rtl/stack_sequencer_if.sv | 21 ++
 rtl/stack_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_stack_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// rtl/stack_sequencer_if.sv - command channel between decode/execute and the stack sequencer
interface stack_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [7:0] cmd_data;
    logic [7:0] cmd_target;
    logic [3:0] flags_in;
    logic [7:0] sp_in;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_data, cmd_target, flags_in, sp_in,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_data, cmd_target, flags_in, sp_in,
        output cmd_ready
    );
endinterface

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - multi-cycle PUSH/POP/CALL/RET/INT/RTI engine driving SP, PC and flags
module stack_sequencer #(
    parameter logic [7:0] STACK_LIMIT = 8'h80,
    parameter logic [7:0] STACK_TOP   = 8'hFF,
    parameter logic [7:0] INT_VECTOR  = 8'h02
) (
    input  logic                    clk,
    input  logic                    reset,
    stack_sequencer_if.slave        cmd,
    output logic [7:0]              dmem_addr,
    output logic [7:0]              dmem_wdata,
    output logic                    dmem_we,
    output logic                    dmem_re,
    input  logic [7:0]              dmem_rdata,
    output logic                    rf_we,
    output logic [1:0]              rf_waddr,
    output logic [7:0]              rf_wdata,
    output logic                    update_sp,
    output logic [7:0]              new_sp,
    output logic                    pc_load,
    output logic [7:0]              pc_value,
    output logic                    flags_load,
    output logic [3:0]              flags_value,
    output logic                    done,
    output logic [1:0]              err_code
);
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_INT  = 3'b101;
    localparam logic [2:0] OP_RTI  = 3'b110;

    typedef enum logic [2:0] {IDLE, W1, W2, RDQ, R1D, R2D, ERR} state_t;

    state_t     state, state_n;
    logic [2:0] op_q;
    logic [1:0] rd_q;
    logic [7:0] data_q, target_q, sp_q;
    logic [3:0] flags_q, rflags_q;
    logic [1:0] err_q, err_d;
    logic       accept;

    // Bounds are compared in 9 bits so that limit+n and sp+n never wrap.
    logic [8:0] sp9, lim9, top9;
    logic       ovf1, ovf2, unf1, unf2;

    assign sp9  = {1'b0, cmd.sp_in};
    assign lim9 = {1'b0, STACK_LIMIT};
    assign top9 = {1'b0, STACK_TOP};
    assign ovf1 = (sp9 + 9'd1) < (lim9 + 9'd1);
    assign ovf2 = (sp9 + 9'd1) < (lim9 + 9'd2);
    assign unf1 = (sp9 + 9'd1) > top9;
    assign unf2 = (sp9 + 9'd2) > top9;

    assign cmd.cmd_ready = (state == IDLE) && !reset;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_NOP;
            rd_q     <= 2'd0;
            data_q   <= 8'd0;
            target_q <= 8'd0;
            sp_q     <= 8'd0;
            flags_q  <= 4'd0;
            rflags_q <= 4'd0;
            err_q    <= 2'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q     <= cmd.cmd_op;
                rd_q     <= cmd.cmd_rd;
                data_q   <= cmd.cmd_data;
                target_q <= cmd.cmd_target;
                sp_q     <= cmd.sp_in;
                flags_q  <= cmd.flags_in;
                err_q    <= err_d;
            end
            if (state == R1D)
                rflags_q <= dmem_rdata[3:0];
        end
    end

    always_comb begin
        state_n     = state;
        err_d       = 2'b00;
        dmem_addr   = 8'd0;
        dmem_wdata  = 8'd0;
        dmem_we     = 1'b0;
        dmem_re     = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = 2'd0;
        rf_wdata    = 8'd0;
        update_sp   = 1'b0;
        new_sp      = 8'd0;
        pc_load     = 1'b0;
        pc_value    = 8'd0;
        flags_load  = 1'b0;
        flags_value = 4'd0;
        done        = 1'b0;
        err_code    = 2'b00;

        if (accept) begin
            case (cmd.cmd_op)
                OP_NOP:           state_n = ERR;
                OP_PUSH, OP_CALL: begin state_n = ovf1 ? ERR : W1; err_d = ovf1 ? 2'b01 : 2'b00; end
                OP_INT:           begin state_n = ovf2 ? ERR : W1; err_d = ovf2 ? 2'b01 : 2'b00; end
                OP_POP: begin
                    if (cmd.cmd_rd == 2'd3) begin state_n = ERR; err_d = 2'b11; end
                    else begin state_n = unf1 ? ERR : RDQ; err_d = unf1 ? 2'b10 : 2'b00; end
                end
                OP_RET:           begin state_n = unf1 ? ERR : RDQ; err_d = unf1 ? 2'b10 : 2'b00; end
                OP_RTI:           begin state_n = unf2 ? ERR : RDQ; err_d = unf2 ? 2'b10 : 2'b00; end
                default:          begin state_n = ERR; err_d = 2'b11; end
            endcase
        end

        if (!reset) begin
            case (state)
                W1: begin
                    dmem_we    = 1'b1;
                    dmem_addr  = sp_q;
                    dmem_wdata = data_q;
                    if (op_q == OP_INT) begin
                        state_n = W2;
                    end else begin
                        update_sp = 1'b1;
                        new_sp    = sp_q - 8'd1;
                        pc_load   = (op_q == OP_CALL);
                        pc_value  = (op_q == OP_CALL) ? target_q : 8'd0;
                        done      = 1'b1;
                        state_n   = IDLE;
                    end
                end
                W2: begin
                    dmem_we    = 1'b1;
                    dmem_addr  = sp_q - 8'd1;
                    dmem_wdata = {4'b0000, flags_q};
                    update_sp  = 1'b1;
                    new_sp     = sp_q - 8'd2;
                    pc_load    = 1'b1;
                    pc_value   = INT_VECTOR;
                    done       = 1'b1;
                    state_n    = IDLE;
                end
                RDQ: begin
                    dmem_re   = 1'b1;
                    dmem_addr = sp_q + 8'd1;
                    state_n   = R1D;
                end
                R1D: begin
                    if (op_q == OP_RTI) begin
                        dmem_re   = 1'b1;
                        dmem_addr = sp_q + 8'd2;
                        state_n   = R2D;
                    end else begin
                        rf_we     = (op_q == OP_POP);
                        rf_waddr  = (op_q == OP_POP) ? rd_q : 2'd0;
                        rf_wdata  = (op_q == OP_POP) ? dmem_rdata : 8'd0;
                        pc_load   = (op_q == OP_RET);
                        pc_value  = (op_q == OP_RET) ? dmem_rdata : 8'd0;
                        update_sp = 1'b1;
                        new_sp    = sp_q + 8'd1;
                        done      = 1'b1;
                        state_n   = IDLE;
                    end
                end
                R2D: begin
                    pc_load     = 1'b1;
                    pc_value    = dmem_rdata;
                    flags_load  = 1'b1;
                    flags_value = rflags_q;
                    update_sp   = 1'b1;
                    new_sp      = sp_q + 8'd2;
                    done        = 1'b1;
                    state_n     = IDLE;
                end
                ERR: begin
                    done     = 1'b1;
                    err_code = err_q;
                    state_n  = IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - directed self-checking bench for stack_sequencer
module tb_stack_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic       dmem_we, dmem_re;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       update_sp, pc_load, flags_load, done;
    logic [7:0] new_sp, pc_value;
    logic [3:0] flags_value;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:255];
    logic watch = 1'b0;
    logic seen_effect = 1'b0;

    stack_sequencer_if cif ();

    stack_sequencer dut (
        .clk(clk), .reset(reset), .cmd(cif.slave),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .update_sp(update_sp), .new_sp(new_sp),
        .pc_load(pc_load), .pc_value(pc_value),
        .flags_load(flags_load), .flags_value(flags_value),
        .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_we) mem[dmem_addr] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= mem[dmem_addr];
        if (watch && (pc_load || update_sp || flags_load)) seen_effect <= 1'b1;
    end

    logic [55:0] obs;
    assign obs = {dmem_we, dmem_re, dmem_addr, dmem_wdata, rf_we, rf_waddr, rf_wdata,
                  update_sp, new_sp, pc_load, pc_value, flags_load, flags_value,
                  done, err_code, cif.cmd_ready};

    function automatic logic [55:0] pk(logic we, logic re, logic [7:0] a, logic [7:0] wd,
                                       logic rwe, logic [1:0] rwa, logic [7:0] rwd,
                                       logic us, logic [7:0] ns, logic pl, logic [7:0] pv,
                                       logic fl, logic [3:0] fv, logic dn, logic [1:0] ec,
                                       logic rdy);
        return {we, re, a, wd, rwe, rwa, rwd, us, ns, pl, pv, fl, fv, dn, ec, rdy};
    endfunction

    function automatic logic [55:0] errv(logic [1:0] ec);
        return pk('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, ec, '0);
    endfunction

    localparam logic [55:0] ZERO = 56'd0;
    localparam logic [55:0] IDLE_V = 56'd1;

    task automatic chk(string tag, logic [55:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk8(string tag, logic [7:0] o, logic [7:0] exp);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [2:0] op, logic [1:0] rd, logic [7:0] data,
                         logic [7:0] target, logic [3:0] fl, logic [7:0] sp);
        cif.cmd_op = op; cif.cmd_rd = rd; cif.cmd_data = data;
        cif.cmd_target = target; cif.flags_in = fl; cif.sp_in = sp;
        cif.cmd_valid = 1'b1;
        tick();
        cif.cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        reset = 1'b1;
        cif.cmd_valid = 1'b0; cif.cmd_op = 3'd1; cif.cmd_rd = 2'd0; cif.cmd_data = 8'd0;
        cif.cmd_target = 8'd0; cif.flags_in = 4'd0; cif.sp_in = 8'hFF;
        tick(); tick();
        chk("reset", ZERO);
        reset = 1'b0;
        tick();
        chk("idle", IDLE_V);

        issue(3'd1, 2'd0, 8'h5A, 8'h00, 4'h0, 8'hFF);
        chk("push_w1", pk('1, '0, 8'hFF, 8'h5A, '0, '0, '0, '1, 8'hFE, '0, '0, '0, '0, '1, 2'd0, '0));
        tick();
        chk("push_idle", IDLE_V);
        chk8("mem_ff_push", mem[8'hFF], 8'h5A);

        issue(3'd2, 2'd1, 8'h00, 8'h00, 4'h0, 8'hFE);
        chk("pop_rdq", pk('0, '1, 8'hFF, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 2'd0, '0));
        tick();
        chk("pop_r1d", pk('0, '0, '0, '0, '1, 2'd1, 8'h5A, '1, 8'hFF, '0, '0, '0, '0, '1, 2'd0, '0));
        tick();

        issue(3'd5, 2'd0, 8'h40, 8'h00, 4'hA, 8'hFF);
        chk("int_w1", pk('1, '0, 8'hFF, 8'h40, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 2'd0, '0));
        tick();
        chk("int_w2", pk('1, '0, 8'hFE, 8'h0A, '0, '0, '0, '1, 8'hFD, '1, 8'h02, '0, '0, '1, 2'd0, '0));
        tick();
        chk8("mem_ff_int", mem[8'hFF], 8'h40);
        chk8("mem_fe_int", mem[8'hFE], 8'h0A);

        issue(3'd6, 2'd0, 8'h00, 8'h00, 4'h0, 8'hFD);
        chk("rti_rdq", pk('0, '1, 8'hFE, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 2'd0, '0));
        tick();
        chk("rti_r1d", pk('0, '1, 8'hFF, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 2'd0, '0));
        tick();
        chk("rti_r2d", pk('0, '0, '0, '0, '0, '0, '0, '1, 8'hFF, '1, 8'h40, '1, 4'hA, '1, 2'd0, '0));
        tick();

        issue(3'd5, 2'd0, 8'h40, 8'h00, 4'hA, 8'h80);
        chk("int_ovf", errv(2'd1));
        tick();
        chk8("mem_80_ovf", mem[8'h80], 8'hEE);
        chk8("mem_7f_ovf", mem[8'h7F], 8'hEE);

        issue(3'd2, 2'd0, 8'h00, 8'h00, 4'h0, 8'hFF);
        chk("pop_unf", errv(2'd2));
        tick();
        issue(3'd2, 2'd3, 8'h00, 8'h00, 4'h0, 8'h90);
        chk("pop_rd3", errv(2'd3));
        tick();
        issue(3'd7, 2'd0, 8'h00, 8'h00, 4'h0, 8'h90);
        chk("op_ill", errv(2'd3));
        tick();
        issue(3'd0, 2'd0, 8'h00, 8'h00, 4'h0, 8'h90);
        chk("nop", errv(2'd0));
        tick();
        issue(3'd6, 2'd0, 8'h00, 8'h00, 4'h0, 8'hFE);
        chk("rti_unf", errv(2'd2));
        tick();

        issue(3'd3, 2'd0, 8'h11, 8'h33, 4'h0, 8'h90);
        chk("call_w1", pk('1, '0, 8'h90, 8'h11, '0, '0, '0, '1, 8'h8F, '1, 8'h33, '0, '0, '1, 2'd0, '0));
        tick();
        chk8("mem_90_call", mem[8'h90], 8'h11);
        issue(3'd4, 2'd0, 8'h00, 8'h00, 4'h0, 8'h8F);
        chk("ret_rdq", pk('0, '1, 8'h90, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 2'd0, '0));
        tick();
        chk("ret_r1d", pk('0, '0, '0, '0, '0, '0, '0, '1, 8'h90, '1, 8'h11, '0, '0, '1, 2'd0, '0));
        tick();

        issue(3'd1, 2'd0, 8'hC3, 8'h00, 4'h0, 8'h80);
        chk("push_limit", pk('1, '0, 8'h80, 8'hC3, '0, '0, '0, '1, 8'h7F, '0, '0, '0, '0, '1, 2'd0, '0));
        tick();
        chk8("mem_80_limit", mem[8'h80], 8'hC3);

        // cmd_valid stays high across a busy POP; the held PUSH is taken only in IDLE
        cif.cmd_op = 3'd2; cif.cmd_rd = 2'd2; cif.sp_in = 8'hFE; cif.cmd_valid = 1'b1;
        tick();
        cif.cmd_op = 3'd1; cif.cmd_data = 8'h77; cif.sp_in = 8'hFF;
        chk("held_rdq", pk('0, '1, 8'hFF, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 2'd0, '0));
        tick();
        chk("held_r1d", pk('0, '0, '0, '0, '1, 2'd2, 8'h40, '1, 8'hFF, '0, '0, '0, '0, '1, 2'd0, '0));
        tick();
        chk("held_idle", IDLE_V);
        tick();
        cif.cmd_valid = 1'b0;
        chk("held_w1", pk('1, '0, 8'hFF, 8'h77, '0, '0, '0, '1, 8'hFE, '0, '0, '0, '0, '1, 2'd0, '0));
        tick();
        chk8("mem_ff_held", mem[8'hFF], 8'h77);

        watch = 1'b1;
        issue(3'd6, 2'd0, 8'h00, 8'h00, 4'h0, 8'hFD);
        tick();
        chk("rst_r1d", pk('0, '1, 8'hFF, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 2'd0, '0));
        reset = 1'b1;
        #1;
        chk("rst_mid", ZERO);
        tick();
        chk("rst_hold", ZERO);
        reset = 1'b0;
        tick();
        chk("rst_idle", IDLE_V);
        tick();
        watch = 1'b0;
        chk8("rst_no_effect", {7'd0, seen_effect}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
